// File: rtl/bus_controller.sv
// CPU-side slave: decodes 12-bit accesses onto RAM, a buffered output FIFO,
// a single-entry input port and a 16-bit instruction-fetch counter.
module bus_controller #(
  parameter int unsigned RAM_WORDS  = 3840,
  parameter string       INIT_FILE  = "",
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clock,
  input  logic        reset,
  inout  wire  [7:0]  dataBus,
  input  logic [11:0] addressBus,
  input  logic        write,
  input  logic        sync,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready
);

  localparam int unsigned RAM_AW = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
  localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);

  localparam logic [11:0] RAM_END  = 12'(RAM_WORDS);
  localparam logic [11:0] A_FIFO   = 12'hF00;
  localparam logic [11:0] A_STATUS = 12'hF01;
  localparam logic [11:0] A_IN     = 12'hF02;
  localparam logic [11:0] A_ACK    = 12'hF03;
  localparam logic [11:0] A_CNT_LO = 12'hF04;
  localparam logic [11:0] A_CNT_HI = 12'hF05;

  logic [7:0]       ram [RAM_WORDS];
  logic [7:0]       fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [CNT_W-1:0] count;
  logic             overflow;
  logic             input_valid;
  logic [7:0]       input_hold;
  logic [15:0]      fetch_cnt;

  logic             wr_en_c, push_c, pop_c, full_c, empty_c, accept_c, ovf_set_c;
  logic             ack_c, capture_c;
  logic [7:0]       status_c, rd_data_c;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Write-side decode; nothing commits while reset is high.
  always_comb begin
    wr_en_c   = write && !reset;
    empty_c   = (count == '0);
    full_c    = (count == CNT_W'(FIFO_DEPTH));
    pop_c     = !empty_c && out_ready;
    push_c    = wr_en_c && (addressBus == A_FIFO);
    accept_c  = push_c && (!full_c || pop_c);
    ovf_set_c = push_c && full_c && !pop_c;
    ack_c     = wr_en_c && (addressBus == A_ACK);
    capture_c = in_valid && !input_valid;
  end

  always_ff @(posedge clock) begin
    if (wr_en_c && (addressBus < RAM_END)) ram[RAM_AW'(addressBus)] <= dataBus;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) fifo_mem[i] <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      overflow    <= 1'b0;
      input_valid <= 1'b0;
      input_hold  <= '0;
      fetch_cnt   <= '0;
    end else begin
      if (accept_c) begin
        fifo_mem[wr_ptr] <= dataBus;
        wr_ptr           <= ptr_inc(wr_ptr);
      end
      if (pop_c) rd_ptr <= ptr_inc(rd_ptr);
      case ({accept_c, pop_c})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (ovf_set_c) overflow <= 1'b1;
      else if (wr_en_c && (addressBus == A_STATUS)) overflow <= 1'b0;
      if (capture_c) input_hold <= in_data;
      // An ack blocks capture this cycle since in_ready was low.
      if (ack_c) input_valid <= 1'b0;
      else if (capture_c) input_valid <= 1'b1;
      if (wr_en_c && (addressBus == A_CNT_LO)) fetch_cnt <= '0;
      else if (sync) fetch_cnt <= fetch_cnt + 16'd1;
    end
  end

  assign out_data  = fifo_mem[rd_ptr];
  assign out_valid = !empty_c;
  assign in_ready  = !input_valid;

  // Zero-latency read mux; the cpu samples within the address cycle.
  always_comb begin
    status_c  = {1'b0, 3'(count), input_valid, overflow, empty_c, full_c};
    rd_data_c = '0;
    if (addressBus < RAM_END) begin
      rd_data_c = ram[RAM_AW'(addressBus)];
    end else begin
      case (addressBus)
        A_FIFO:   rd_data_c = out_data;
        A_STATUS: rd_data_c = status_c;
        A_IN:     rd_data_c = input_hold;
        A_CNT_LO: rd_data_c = fetch_cnt[7:0];
        A_CNT_HI: rd_data_c = fetch_cnt[15:8];
        default:  rd_data_c = '0;
      endcase
    end
  end

  assign dataBus = (!write && !reset) ? rd_data_c : {8{1'bz}};

endmodule

// File: tb/tb_bus_controller.sv
// Directed + randomized bench for bus_controller against a queue-based model
// of the memory map, output FIFO, input port and fetch counter.
module tb_bus_controller;

  localparam int unsigned DEPTH = 4;

  logic        clock = 1'b0;
  logic        reset, write, sync, out_ready, in_valid;
  logic [11:0] addr;
  logic [7:0]  wdata, in_data;
  logic [7:0]  out_data;
  logic        out_valid, in_ready;
  wire  [7:0]  data_bus;

  assign data_bus = write ? wdata : {8{1'bz}};

  bus_controller #(.RAM_WORDS(3840), .INIT_FILE(""), .FIFO_DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .dataBus(data_bus), .addressBus(addr),
    .write(write), .sync(sync), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  logic [7:0]  m_ram [4096];
  bit          m_known [4096];
  logic [7:0]  q [$];
  bit          m_ovf, m_iv;
  logic [7:0]  m_hold;
  int unsigned m_cnt;

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Apply one clock edge to the model using the inputs currently driven, then to the DUT.
  task automatic tick();
    bit pop, cap;
    if (reset) begin
      q.delete(); m_ovf = 0; m_iv = 0; m_hold = 8'h00; m_cnt = 0;
    end else begin
      pop = (q.size() > 0) && out_ready;
      cap = in_valid && !m_iv;
      if (write && addr < 12'hF00) begin m_ram[addr] = wdata; m_known[addr] = 1; end
      if (write && addr == 12'hF01) m_ovf = 0;
      if (write && addr == 12'hF04) m_cnt = 0;
      else if (sync) m_cnt = (m_cnt + 1) % 65536;
      if (pop) void'(q.pop_front());
      if (write && addr == 12'hF00) begin
        if (q.size() < DEPTH) q.push_back(wdata);
        else m_ovf = 1;
      end
      if (cap) m_hold = in_data;
      if (write && addr == 12'hF03) m_iv = 0;
      else if (cap) m_iv = 1;
    end
    @(posedge clock);
    #1;
  endtask

  task automatic wr(input logic [11:0] a, input logic [7:0] d);
    addr = a; wdata = d; write = 1'b1;
    tick();
    write = 1'b0;
  endtask

  task automatic rd(input logic [11:0] a, output logic [7:0] v);
    addr = a; write = 1'b0;
    #1;
    v = data_bus;
  endtask

  task automatic exp_rd(input logic [11:0] a, output logic [7:0] e, output bit ok);
    ok = 1;
    e  = 8'h00;
    if (a < 12'hF00) begin
      ok = m_known[a];
      e  = m_ram[a];
    end else begin
      case (a)
        12'hF00: begin ok = (q.size() > 0); if (ok) e = q[0]; end
        12'hF01: e = {1'b0, 3'(q.size()), m_iv, m_ovf, q.size() == 0, q.size() == DEPTH};
        12'hF02: e = m_hold;
        12'hF04: e = 8'(m_cnt);
        12'hF05: e = 8'(m_cnt >> 8);
        default: e = 8'h00;
      endcase
    end
  endtask

  task automatic chk_rd(input string tag, input logic [11:0] a);
    logic [7:0] v, e;
    bit ok;
    rd(a, v);
    exp_rd(a, e, ok);
    if (ok) chk8(tag, v, e);
  endtask

  task automatic chk_out(input string tag);
    chk1({tag, "_out_valid"}, out_valid, q.size() > 0);
    chk1({tag, "_in_ready"}, in_ready, !m_iv);
    if (q.size() > 0) chk8({tag, "_out_data"}, out_data, q[0]);
  endtask

  function automatic logic [11:0] pick_addr();
    case ($urandom % 5)
      0, 1:    return 12'(($urandom % 8));
      2:       return 12'hF00 + 12'(($urandom % 8));
      3:       return ($urandom % 2) ? 12'hF80 : 12'hFFF;
      default: return 12'h123;
    endcase
  endfunction

  logic [7:0] v;
  logic [7:0] seq [4];

  initial begin
    reset = 1; write = 0; sync = 0; out_ready = 0; in_valid = 0;
    addr = '0; wdata = '0; in_data = '0;
    for (int i = 0; i < 4096; i++) m_known[i] = 0;
    tick(); tick();
    reset = 0;

    // Reset state
    chk1("rst_out_valid", out_valid, 1'b0);
    chk1("rst_in_ready", in_ready, 1'b1);
    chk8("rst_out_data", out_data, 8'h00);
    rd(12'hF01, v); chk8("rst_status", v, 8'h02);
    rd(12'hF04, v); chk8("rst_cnt_lo", v, 8'h00);

    // RAM write/read and unmapped read
    wr(12'h000, 8'h5A);
    wr(12'h123, 8'h3C);
    for (int i = 1; i < 8; i++) wr(12'(i), 8'(i * 17));
    rd(12'h000, v); chk8("ram_000", v, 8'h5A);
    rd(12'h123, v); chk8("ram_123", v, 8'h3C);
    rd(12'hF80, v); chk8("unmapped_f80", v, 8'h00);
    chk_rd("ram_005", 12'h005);

    // FIFO overflow then drain
    out_ready = 0;
    wr(12'hF00, 8'h11); wr(12'hF00, 8'h22); wr(12'hF00, 8'h33);
    wr(12'hF00, 8'h44); wr(12'hF00, 8'h55);
    rd(12'hF01, v); chk8("status_full_ovf", v, 8'h45);
    rd(12'hF00, v); chk8("peek_head", v, 8'h11);
    seq = '{8'h11, 8'h22, 8'h33, 8'h44};
    out_ready = 1;
    for (int i = 0; i < 4; i++) begin
      chk8("drain_seq", out_data, seq[i]);
      tick();
    end
    chk1("drain_empty", out_valid, 1'b0);
    rd(12'hF01, v); chk8("status_drained", v, 8'h06);
    wr(12'hF01, 8'hFF);
    rd(12'hF01, v); chk8("status_ovf_clr", v, 8'h02);

    // Push while full with simultaneous pop
    out_ready = 0;
    wr(12'hF00, 8'hAA); wr(12'hF00, 8'hBB); wr(12'hF00, 8'hCC); wr(12'hF00, 8'hDD);
    out_ready = 1;
    wr(12'hF00, 8'h99);
    out_ready = 0;
    rd(12'hF01, v); chk8("status_full_no_ovf", v, 8'h41);
    out_ready = 1;
    seq = '{8'hBB, 8'hCC, 8'hDD, 8'h99};
    for (int i = 0; i < 4; i++) begin
      chk8("pushpop_seq", out_data, seq[i]);
      tick();
    end
    chk1("pushpop_empty", out_valid, 1'b0);
    out_ready = 0;

    // Input port capture and ack
    in_valid = 1; in_data = 8'hA7;
    tick();
    chk1("in_ready_low", in_ready, 1'b0);
    rd(12'hF02, v); chk8("in_hold_a7", v, 8'hA7);
    rd(12'hF01, v); chk1("status_iv", v[3], 1'b1);
    in_data = 8'hB8;
    wr(12'hF03, 8'h00);
    chk1("in_ready_after_ack", in_ready, 1'b1);
    tick();
    rd(12'hF02, v); chk8("in_hold_b8", v, 8'hB8);
    chk1("in_ready_recapture", in_ready, 1'b0);
    in_valid = 0;
    rd(12'hF03, v); chk8("ack_read", v, 8'h00);

    // Fetch counter
    wr(12'hF04, 8'h00);
    sync = 1;
    repeat (300) tick();
    sync = 0;
    rd(12'hF04, v); chk8("cnt300_lo", v, 8'h2C);
    rd(12'hF05, v); chk8("cnt300_hi", v, 8'h01);
    sync = 1;
    wr(12'hF04, 8'h55);
    sync = 0;
    rd(12'hF04, v); chk8("cnt_clr_lo", v, 8'h00);
    rd(12'hF05, v); chk8("cnt_clr_hi", v, 8'h00);
    sync = 1;
    repeat (65536) tick();
    sync = 0;
    rd(12'hF04, v); chk8("cnt_wrap_lo", v, 8'h00);
    rd(12'hF05, v); chk8("cnt_wrap_hi", v, 8'h00);

    // Mid-operation reset
    wr(12'hF03, 8'h00);
    wr(12'hF00, 8'h01); wr(12'hF00, 8'h02);
    in_valid = 1; in_data = 8'h6E;
    tick();
    in_valid = 0;
    sync = 1;
    repeat (10) tick();
    sync = 0;
    rd(12'hF04, v); chk8("cnt10", v, 8'h0A);
    chk1("pre_rst_valid", out_valid, 1'b1);
    reset = 1;
    wr(12'h124, 8'hEE);
    reset = 0;
    chk1("mid_rst_out_valid", out_valid, 1'b0);
    chk1("mid_rst_in_ready", in_ready, 1'b1);
    chk8("mid_rst_out_data", out_data, 8'h00);
    rd(12'hF01, v); chk8("mid_rst_status", v, 8'h02);
    rd(12'hF04, v); chk8("mid_rst_cnt_lo", v, 8'h00);
    rd(12'hF05, v); chk8("mid_rst_cnt_hi", v, 8'h00);
    rd(12'h123, v); chk8("mid_rst_ram", v, 8'h3C);

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      reset     = ($urandom % 150) == 0;
      write     = ($urandom % 3) == 0;
      addr      = pick_addr();
      wdata     = 8'($urandom);
      out_ready = ($urandom % 3) != 0;
      in_valid  = ($urandom % 2) == 0;
      in_data   = 8'($urandom);
      sync      = ($urandom % 2) == 0;
      if (!write && !reset) chk_rd("rand_read", addr);
      tick();
      write = 0;
      reset = 0;
      chk_out("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
